// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: memory access sizes, FSM encoding and defaults.
// Access-size codes are also used by the data memory and the decode stage.
package load_store_unit_pkg;

    localparam int unsigned LsuWidth   = 32;
    localparam int unsigned LsuTimeout = 16;

    typedef enum logic [1:0] {
        DmWord    = 2'd0,
        DmHalf    = 2'd1,
        DmByte    = 2'd2,
        DmIllegal = 2'd3
    } dm_mode_e;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StErr     = 3'd1,
        StStSetup = 3'd2,
        StStPulse = 3'd3,
        StStHold  = 3'd4,
        StLdSetup = 3'd5,
        StLdWait  = 3'd6,
        StResp    = 3'd7
    } lsu_state_e;

    // Word accesses need addr[1:0]==0, halfword accesses need addr[0]==0.
    function automatic logic is_misaligned(input logic [1:0] mode, input logic [1:0] addr_lo);
        return ((mode == DmWord) && (addr_lo != 2'b00)) || ((mode == DmHalf) && addr_lo[0]);
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Pipeline request/response handshake plus the data-memory control signals of the LSU.
// The shared data bus itself is a resolved net and is carried as a separate inout port.
interface load_store_unit_if
    import load_store_unit_pkg::*;
#(
    parameter int unsigned WIDTH = LsuWidth
);
    logic             req_valid;
    logic             req_ready;
    logic             req_we;
    logic [1:0]       req_mode;
    logic             req_signed;
    logic [WIDTH-1:0] req_addr;
    logic [WIDTH-1:0] req_wdata;
    logic             resp_valid;
    logic             resp_ready;
    logic [WIDTH-1:0] resp_rdata;
    logic             resp_err;
    logic [WIDTH-1:0] dmem_addr;
    logic             wr;
    logic             rd;
    logic             rd_st;
    logic [1:0]       data_mode;

    modport master (
        input  req_valid, req_we, req_mode, req_signed, req_addr, req_wdata, resp_ready, rd_st,
        output req_ready, resp_valid, resp_rdata, resp_err, dmem_addr, wr, rd, data_mode
    );

    modport slave (
        output req_valid, req_we, req_mode, req_signed, req_addr, req_wdata, resp_ready, rd_st,
        input  req_ready, resp_valid, resp_rdata, resp_err, dmem_addr, wr, rd, data_mode
    );
endinterface

// File: rtl/lsu_load_extend.sv
// Sign/zero extension of load data returned right-justified by the data memory.
// Word loads pass through untouched.
module lsu_load_extend
    import load_store_unit_pkg::*;
#(
    parameter int unsigned WIDTH = LsuWidth
) (
    input  logic [WIDTH-1:0] data,
    input  logic [1:0]       mode,
    input  logic             is_signed,
    output logic [WIDTH-1:0] ext
);

    always_comb begin
        ext = data;
        case (mode)
            DmHalf: ext = is_signed ? {{(WIDTH-16){data[15]}}, data[15:0]}
                                    : {{(WIDTH-16){1'b0}}, data[15:0]};
            DmByte: ext = is_signed ? {{(WIDTH-8){data[7]}}, data[7:0]}
                                    : {{(WIDTH-8){1'b0}}, data[7:0]};
            default: ext = data;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one request at a time, checks it, sequences the memory wr/rd strobes
// on the shared bus and returns extended load data or an error to the pipeline.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int unsigned WIDTH       = LsuWidth,
    parameter int unsigned TIMEOUT     = LsuTimeout,
    parameter bit          CHECK_ALIGN = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    load_store_unit_if.master    lsu,
    inout  wire  [WIDTH-1:0]     dmem_data
);

    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

    lsu_state_e       state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [1:0]       mode_q, mode_d;
    logic             signed_q, signed_d;
    logic [WIDTH-1:0] addr_q, addr_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             err_q, err_d;
    logic             wr_q, rd_q, oe_q, resp_valid_q;
    logic             bad_req;
    logic [WIDTH-1:0] load_ext;

    lsu_load_extend #(
        .WIDTH (WIDTH)
    ) u_load_extend (
        .data      (dmem_data),
        .mode      (mode_q),
        .is_signed (signed_q),
        .ext       (load_ext)
    );

    assign bad_req = (lsu.req_mode == DmIllegal) ||
                     (CHECK_ALIGN && is_misaligned(lsu.req_mode, lsu.req_addr[1:0]));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mode_d   = mode_q;
        signed_d = signed_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        case (state_q)
            StIdle: begin
                if (lsu.req_valid) begin
                    rdata_d = '0;
                    err_d   = 1'b0;
                    if (bad_req) begin
                        state_d = StErr;
                    end else begin
                        // Address/size only change for accepted accesses, so rejected
                        // requests leave the memory port untouched.
                        mode_d   = lsu.req_mode;
                        signed_d = lsu.req_signed;
                        addr_d   = lsu.req_addr;
                        wdata_d  = lsu.req_wdata;
                        state_d  = lsu.req_we ? StStSetup : StLdSetup;
                    end
                end
            end
            StErr: begin
                err_d   = 1'b1;
                state_d = StResp;
            end
            StStSetup: state_d = StStPulse;
            StStPulse: state_d = StStHold;
            StStHold:  state_d = StResp;
            StLdSetup: begin
                cnt_d   = '0;
                state_d = StLdWait;
            end
            StLdWait: begin
                // rd_st in the first wait cycle may still reflect the previous read.
                if ((cnt_q != '0) && lsu.rd_st) begin
                    rdata_d = load_ext;
                    state_d = StResp;
                end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StResp: begin
                if (lsu.resp_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Strobes and bus enable are registered from the next state to keep them glitch-free.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            mode_q       <= 2'd0;
            signed_q     <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
            wr_q         <= 1'b0;
            rd_q         <= 1'b0;
            oe_q         <= 1'b0;
            resp_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            mode_q       <= mode_d;
            signed_q     <= signed_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
            wr_q         <= (state_d == StStPulse);
            rd_q         <= (state_d == StLdWait);
            oe_q         <= (state_d == StStSetup) || (state_d == StStPulse) ||
                            (state_d == StStHold);
            resp_valid_q <= (state_d == StResp);
        end
    end

    assign lsu.req_ready  = (state_q == StIdle);
    assign lsu.resp_valid = resp_valid_q;
    assign lsu.resp_rdata = rdata_q;
    assign lsu.resp_err   = err_q;
    assign lsu.dmem_addr  = addr_q;
    assign lsu.data_mode  = mode_q;
    assign lsu.wr         = wr_q;
    assign lsu.rd         = rd_q;
    assign dmem_data      = oe_q ? wdata_q : {WIDTH{1'bz}};

endmodule

// File: tb/tb_load_store_unit.sv
// Randomised bench for load_store_unit with a big-endian byte memory model on the bus and an
// independent reference memory that predicts data, errors, latency and strobe counts.
module tb_load_store_unit;

    localparam int unsigned W  = 32;
    localparam int unsigned TO = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    wire  [W-1:0] dmem_data;

    load_store_unit_if #(.WIDTH(W)) bus ();

    load_store_unit #(
        .WIDTH       (W),
        .TIMEOUT     (TO),
        .CHECK_ALIGN (1'b1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .lsu       (bus),
        .dmem_data (dmem_data)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]   mem     [256];
    logic [7:0]   ref_mem [256];
    logic [W-1:0] mem_rdata = '0;
    int           mem_lat = 2;
    int           rd_k = 0;
    int           wr_cnt = 0;
    int           rd_cnt = 0;
    int           overlap_cnt = 0;
    logic [W-1:0] last_rdata = '0;
    logic [7:0]   wa, ra;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Memory model: acts on strobe rising edges, drives the bus while rd is high.
    assign dmem_data = bus.rd ? mem_rdata : {W{1'bz}};

    always @(posedge bus.wr) begin
        wa = bus.dmem_addr[7:0];
        case (bus.data_mode)
            2'd0: begin
                mem[wa] = dmem_data[31:24]; mem[wa + 8'd1] = dmem_data[23:16];
                mem[wa + 8'd2] = dmem_data[15:8]; mem[wa + 8'd3] = dmem_data[7:0];
            end
            2'd1: begin mem[wa] = dmem_data[15:8]; mem[wa + 8'd1] = dmem_data[7:0]; end
            2'd2: mem[wa] = dmem_data[7:0];
            default: ;
        endcase
    end

    always @(posedge bus.rd) begin
        ra = bus.dmem_addr[7:0];
        case (bus.data_mode)
            2'd0: mem_rdata = {mem[ra], mem[ra + 8'd1], mem[ra + 8'd2], mem[ra + 8'd3]};
            2'd1: mem_rdata = {16'h0, mem[ra], mem[ra + 8'd1]};
            2'd2: mem_rdata = {24'h0, mem[ra]};
            default: mem_rdata = '0;
        endcase
    end

    // rd_st is left stale in the first rd cycle, then answers once rd has been high mem_lat cycles.
    always @(negedge clk) begin
        if (bus.rd) begin
            rd_k = rd_k + 1;
            if (rd_k >= 2) bus.rd_st = (rd_k >= mem_lat);
            rd_cnt = rd_cnt + 1;
        end else begin
            rd_k = 0;
        end
        if (bus.wr) wr_cnt = wr_cnt + 1;
        if (bus.wr && bus.rd) overlap_cnt = overlap_cnt + 1;
    end

    task automatic ref_store(input logic [1:0] mode, input logic [7:0] a, input logic [31:0] d);
        if (mode == 2'd0) begin
            for (int i = 0; i < 4; i++) ref_mem[8'(a + i)] = 8'(d >> (8 * (3 - i)));
        end else if (mode == 2'd1) begin
            for (int i = 0; i < 2; i++) ref_mem[8'(a + i)] = 8'(d >> (8 * (1 - i)));
        end else if (mode == 2'd2) begin
            ref_mem[a] = d[7:0];
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [1:0] mode, input bit sgn,
                                             input logic [7:0] a);
        logic [15:0] h;
        logic [7:0]  b;
        int          s;
        if (mode == 2'd0) return {ref_mem[a], ref_mem[8'(a + 1)], ref_mem[8'(a + 2)],
                                  ref_mem[8'(a + 3)]};
        if (mode == 2'd1) begin
            h = {ref_mem[a], ref_mem[8'(a + 1)]};
            s = sgn ? int'($signed(h)) : int'(h);
            return 32'(s);
        end
        b = ref_mem[a];
        s = sgn ? int'($signed(b)) : int'(b);
        return 32'(s);
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic drive_req(input bit we, input logic [1:0] mode, input bit sgn,
                             input logic [31:0] addr, input logic [31:0] wdata);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_mode   = mode;
        bus.req_signed = sgn;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
    endtask

    task automatic do_req(input bit we, input logic [1:0] mode, input bit sgn,
                          input logic [31:0] addr, input logic [31:0] wdata, input int lat,
                          input int hold);
        logic [31:0] exp_data = '0;
        bit          exp_err;
        int          exp_k, exp_wr = 0, exp_rd = 0, eff, k = 0;
        bit          stable = 1'b1;
        logic [31:0] r0;
        logic        e0;

        exp_err = (mode == 2'd3) || (mode == 2'd0 && addr[1:0] != 2'b00) ||
                  (mode == 2'd1 && addr[0]);
        eff = (lat < 2) ? 2 : lat;
        if (exp_err) begin
            exp_k = 2;
        end else if (we) begin
            exp_k = 4; exp_wr = 1;
            ref_store(mode, addr[7:0], wdata);
        end else if (eff > int'(TO)) begin
            exp_err = 1'b1; exp_k = TO + 2; exp_rd = TO;
        end else begin
            exp_k = eff + 2; exp_rd = eff;
            exp_data = ref_load(mode, sgn, addr[7:0]);
        end

        @(negedge clk);
        check("req_ready_idle", {31'b0, bus.req_ready}, 1);
        drive_req(we, mode, sgn, addr, wdata);
        mem_lat = lat; wr_cnt = 0; rd_cnt = 0;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        while (k < 64) begin
            @(negedge clk);
            k++;
            if (bus.resp_valid) break;
        end
        if (!bus.resp_valid) begin
            check("resp_seen", 0, 1);
            apply_reset();
            return;
        end
        check("resp_latency", k, exp_k);
        check("resp_rdata", bus.resp_rdata, exp_data);
        check("resp_err", {31'b0, bus.resp_err}, {31'b0, exp_err});
        if (!exp_err) begin
            check("dmem_addr", bus.dmem_addr, addr);
            check("data_mode", {30'b0, bus.data_mode}, {30'b0, mode});
        end
        last_rdata = bus.resp_rdata;
        r0 = bus.resp_rdata; e0 = bus.resp_err;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (!bus.resp_valid || bus.resp_rdata !== r0 || bus.resp_err !== e0 ||
                bus.req_ready) stable = 1'b0;
        end
        if (hold > 0) check("resp_hold_stable", {31'b0, stable}, 1);
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1 bus.resp_ready = 1'b0;
        check("wr_pulses", wr_cnt, exp_wr);
        check("rd_cycles", rd_cnt, exp_rd);
    endtask

    // Issue a store or load, assert reset in the middle of the strobe phase.
    task automatic abort_req(input bit we);
        bit quiet = 1'b1;
        @(negedge clk);
        drive_req(we, 2'd0, 1'b0, 32'h8, 32'h1234_5678);
        mem_lat = 40;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        if (we) check("abort_wr_high", {31'b0, bus.wr}, 1);
        else check("abort_rd_high", {31'b0, bus.rd}, 1);
        if (!we) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_wr_low", {31'b0, bus.wr}, 0);
        check("abort_rd_low", {31'b0, bus.rd}, 0);
        check("abort_no_resp", {31'b0, bus.resp_valid}, 0);
        rst = 1'b0;
        // wr had already risen, so the memory took the aborted store.
        if (we) ref_store(2'd0, 8'h8, 32'h1234_5678);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.resp_valid) quiet = 1'b0;
        end
        check("abort_quiet", {31'b0, quiet}, 1);
        check("abort_ready", {31'b0, bus.req_ready}, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit          we, sgn;
        logic [1:0]  mode;
        logic [31:0] addr;
        int          lat;

        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_mode = 2'd0; bus.req_signed = 1'b0;
        bus.req_addr = '0; bus.req_wdata = '0; bus.resp_ready = 1'b0; bus.rd_st = 1'b0;
        for (int i = 0; i < 256; i++) begin
            mem[i] = 8'($urandom);
            ref_mem[i] = mem[i];
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_req_ready", {31'b0, bus.req_ready}, 1);
        check("rst_resp_valid", {31'b0, bus.resp_valid}, 0);
        check("rst_resp_err", {31'b0, bus.resp_err}, 0);
        check("rst_resp_rdata", bus.resp_rdata, 0);
        check("rst_dmem_addr", bus.dmem_addr, 0);
        check("rst_data_mode", {30'b0, bus.data_mode}, 0);
        check("rst_wr", {31'b0, bus.wr}, 0);
        check("rst_rd", {31'b0, bus.rd}, 0);

        do_req(1'b1, 2'd0, 1'b0, 32'h4, 32'hDEAD_BEEF, 2, 0);
        check("mem4", {24'b0, mem[4]}, 32'hDE);
        check("mem5", {24'b0, mem[5]}, 32'hAD);
        check("mem6", {24'b0, mem[6]}, 32'hBE);
        check("mem7", {24'b0, mem[7]}, 32'hEF);
        do_req(1'b0, 2'd1, 1'b1, 32'h4, 32'h0, 2, 0);
        check("ld_half_signed", last_rdata, 32'hFFFF_DEAD);
        do_req(1'b0, 2'd1, 1'b0, 32'h4, 32'h0, 2, 0);
        check("ld_half_unsigned", last_rdata, 32'h0000_DEAD);
        do_req(1'b0, 2'd2, 1'b1, 32'h7, 32'h0, 2, 0);
        check("ld_byte_signed", last_rdata, 32'hFFFF_FFEF);
        do_req(1'b0, 2'd0, 1'b0, 32'h2, 32'h0, 2, 0);
        do_req(1'b0, 2'd3, 1'b0, 32'h0, 32'h0, 2, 0);
        do_req(1'b0, 2'd0, 1'b0, 32'h4, 32'h0, 20, 0);
        do_req(1'b0, 2'd0, 1'b0, 32'h4, 32'h0, 3, 0);
        check("ld_word_lat3", last_rdata, 32'hDEAD_BEEF);
        do_req(1'b0, 2'd0, 1'b0, 32'h4, 32'h0, 2, 5);
        abort_req(1'b1);
        abort_req(1'b0);
        do_req(1'b0, 2'd0, 1'b0, 32'h8, 32'h0, 2, 0);

        for (int i = 0; i < 200; i++) begin
            we   = 1'($urandom_range(0, 1));
            sgn  = 1'($urandom_range(0, 1));
            mode = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            addr = $urandom;
            if ($urandom_range(0, 3) != 0) addr[1:0] = 2'b00;
            lat  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(15, 20))
                                                : int'($urandom_range(1, 5));
            do_req(we, mode, sgn, addr, $urandom, lat, int'($urandom_range(0, 3)));
        end

        check("wr_rd_overlap", overlap_cnt, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the CPU execute/memory stage and the data memory; it is the sole driver of the data-memory port.
- Accepts one load or store request at a time over a valid/ready handshake.
- Checks alignment, then sequences the memory's edge-triggered wr/rd strobes on the shared tri-state bus.
- Sign- or zero-extends load data and returns a response (data or error) to the pipeline.

Parameters:
WIDTH, `WIDTH (32), address/data width
TIMEOUT, 16, max cycles rd may be held high waiting for rd_st before an error response
CHECK_ALIGN, 1, 1 = misaligned word/halfword accesses return error; 0 = pass through unchecked

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  LSU idle and able to accept
req_we  input  1  1 = store, 0 = load
req_mode  input  2  0 word, 1 halfword, 2 byte, 3 illegal
req_signed  input  1  load sign-extension enable
req_addr  input  WIDTH  byte address
req_wdata  input  WIDTH  store data (right-justified)
resp_valid  output  1  response available
resp_ready  input  1  pipeline accepts response
resp_rdata  output  WIDTH  extended load data (0 for stores and errors)
resp_err  output  1  misaligned, illegal mode, or read timeout
dmem_addr  output  WIDTH  memory address
dmem_data  inout  WIDTH  shared data bus; LSU drives only in store states, else Z
wr  output  1  store strobe, memory acts on rising edge
rd  output  1  load strobe, memory acts on rising edge and drives bus while high
rd_st  input  1  memory read-status
data_mode  output  2  access size to memory

Behaviour:
- Reset (synchronous, rst=1 at clk edge):
  - state IDLE; wr=0, rd=0; bus released.
  - req_ready=1 after reset; resp_valid=0, resp_err=0, resp_rdata=0, dmem_addr=0, data_mode=0.
  - A request in flight is dropped with no response. wr/rd fall in the reset cycle.
- States: IDLE, ERR, ST_SETUP, ST_PULSE, ST_HOLD, LD_SETUP, LD_WAIT, RESP.
- IDLE:
  - req_ready=1. Accept on req_valid at edge T: latch we/mode/signed/addr/wdata.
  - Error if mode==3, or (CHECK_ALIGN and ((mode==0 and addr[1:0]!=0) or (mode==1 and addr[0]!=0))) -> ERR.
  - Otherwise -> ST_SETUP or LD_SETUP.
- ERR: no memory activity; go to RESP with resp_err=1 (response visible T+2).
- Store path:
  - ST_SETUP (T+1): addr, data_mode and bus driven, wr=0.
  - ST_PULSE (T+2): wr=1.
  - ST_HOLD (T+3): wr=0, bus still driven.
  - -> RESP: resp_valid=1 at T+4; bus released on entering RESP.
  - Setup and hold of addr/data around the wr rising edge are each at least one full cycle.
- Load path:
  - LD_SETUP (T+1): addr and data_mode driven, rd=0, bus Z.
  - LD_WAIT (from T+2): rd=1. rd_st is ignored in the first LD_WAIT cycle, because it may be stale from the previous read.
  - From the second cycle, rd_st==1 at an edge: capture dmem_data, extend, drop rd, -> RESP (minimum resp_valid at T+4).
  - Wait counter reaching TIMEOUT without rd_st: rd=0, resp_err=1, resp_rdata=0, -> RESP.
- Extension: the memory returns halfword/byte zero-extended in the low bits.
  - req_signed=1: halfword {16{d[15]}, d[15:0]}, byte {24{d[7]}, d[7:0]}.
  - Word loads are never modified.
- RESP:
  - resp_valid held with stable rdata/err until resp_valid & resp_ready at an edge, then -> IDLE.
  - req_ready=0 in every non-IDLE state, so there is no overlap between requests.
  - Back-to-back minimum issue interval is 5 cycles when resp_ready is tied high.
- Simultaneous wr and rd never occur.
- LSU never drives dmem_data while rd=1. There is one cycle of bus turnaround (RESP or SETUP) between a read and a store drive.
- Addresses are passed unmodified; the memory handles out-of-range addresses.

Decomposition:
- Parameters.v gains:
  - `DM_WORD=0, `DM_HALF=1, `DM_BYTE=2, shared with the memory and decode stage.
  - The LSU state encodings (3-bit).
  - `LSU_TIMEOUT default.
- One combinational sub-module, lsu_load_extend: inputs data, mode, signed; output extended word. It is reused by decode-stage forwarding checks.

Test Plan:
- Store word 0xDEADBEEF to addr 0x4 -> wr high exactly one cycle at T+2; memory bytes 4..7 = DE AD BE EF; resp_valid at T+4, resp_err=0.
- Load halfword signed from addr 0x4 after the above -> resp_rdata=0xFFFFDEAD. Same access unsigned -> 0x0000DEAD. Byte signed at addr 0x7 -> 0xFFFFFFEF.
- Word load at addr 0x2, and mode=3 at addr 0x0 -> no wr/rd pulse, resp_err=1, resp_rdata=0, resp_valid at T+2.
- Memory model withholds rd_st for 16 cycles -> rd falls, resp_err=1. Model answering on the 3rd LD_WAIT cycle -> correct data, no error.
- resp_ready held low 5 cycles -> resp_valid and resp_rdata stable, req_ready=0 throughout; next request accepted the cycle after the handshake.
- rst asserted during ST_PULSE and during LD_WAIT -> wr/rd=0 and bus Z next cycle, no resp_valid, req_ready=1 after reset releases.
